// File: rtl/sha_word_window.sv
// sha_word_window
//   Sliding window of SHA-256 message-schedule words. Slot 0 is the oldest
//   word and slot DEPTH-1 the newest. Supports shift-in, indexed load,
//   synchronous clear, a saturating fill count and four fixed schedule taps.
//
// Ports
//   CLK        rising-edge clock
//   RST        asynchronous reset, active-low
//   clear      synchronous clear of window and fill count (highest priority)
//   shift      shift data_i into the newest slot (beats load)
//   load       write data_i into slot load_idx (ignored if load_idx >= DEPTH)
//   load_idx   slot index for load
//   data_i     write data for shift or load
//   rd_idx     read index
//   rd_data_o  combinational read of slot rd_idx (0 when out of range)
//   tap_*_o    slot contents at TAP_A..TAP_D
//   count_o    saturating count of words shifted in since reset/clear
//   full_o     registered (count_o == DEPTH)
//   drop_o     registered one-cycle pulse per shift that discards the oldest word
module sha_word_window #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAP_A = 0,
  parameter int unsigned TAP_B = 1,
  parameter int unsigned TAP_C = 9,
  parameter int unsigned TAP_D = 14
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             shift,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [WIDTH-1:0] data_i,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [WIDTH-1:0] tap_a_o,
  output logic [WIDTH-1:0] tap_b_o,
  output logic [WIDTH-1:0] tap_c_o,
  output logic [WIDTH-1:0] tap_d_o,
  output logic [IDX_W:0]   count_o,
  output logic             full_o,
  output logic             drop_o
);

  if (TAP_A >= DEPTH || TAP_B >= DEPTH || TAP_C >= DEPTH || TAP_D >= DEPTH) begin : g_bad_tap
    $fatal(1, "sha_word_window: tap index outside 0..DEPTH-1");
  end
  if ((64'd1 << IDX_W) < 64'(DEPTH)) begin : g_bad_idx
    $fatal(1, "sha_word_window: 2**IDX_W < DEPTH");
  end
  if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
    $fatal(1, "sha_word_window: DEPTH outside 2..64");
  end

  localparam logic [IDX_W:0] CNT_FULL = DEPTH[IDX_W:0];

  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [WIDTH-1:0] slot_d [DEPTH];
  logic [IDX_W:0]   count_q, count_d;
  logic             full_q, full_d;
  logic             drop_q, drop_d;

  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    drop_d  = 1'b0;
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) slot_d[i] = '0;
      count_d = '0;
    end else if (shift) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) slot_d[i] = slot_q[i+1];
      slot_d[DEPTH-1] = data_i;
      // full_q mirrors count_q == DEPTH, so it doubles as the saturation flag
      if (full_q) drop_d = 1'b1;
      else        count_d = count_q + 1'b1;
    end else if (load) begin
      // Out-of-range indices match no slot and therefore write nothing
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (load_idx == i[IDX_W-1:0]) slot_d[i] = data_i;
      end
    end
    full_d = (count_d == CNT_FULL);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
      count_q <= count_d;
      full_q  <= full_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_idx == i[IDX_W-1:0]) rd_data_o = slot_q[i];
    end
  end

  assign tap_a_o = slot_q[TAP_A];
  assign tap_b_o = slot_q[TAP_B];
  assign tap_c_o = slot_q[TAP_C];
  assign tap_d_o = slot_q[TAP_D];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign drop_o  = drop_q;

endmodule

// File: tb/tb_sha_word_window.sv
`timescale 1ns/10ps
module tb_sha_word_window;

  logic        clk;
  logic        rst_n;

  // default-geometry instance (DEPTH 16)
  logic        clear, shift, load;
  logic [3:0]  load_idx, rd_idx;
  logic [31:0] data;
  logic [31:0] rd_data, tap_a, tap_b, tap_c, tap_d;
  logic [4:0]  count;
  logic        full, drop;

  // DEPTH 12 instance for range checks
  logic        s_clear, s_shift, s_load;
  logic [3:0]  s_load_idx, s_rd_idx;
  logic [31:0] s_data;
  logic [31:0] s_rd_data, s_tap_a, s_tap_b, s_tap_c, s_tap_d;
  logic [4:0]  s_count;
  logic        s_full, s_drop;

  int checks = 0;
  int errors = 0;

  sha_word_window u_dut (
    .CLK(clk), .RST(rst_n), .clear(clear), .shift(shift), .load(load),
    .load_idx(load_idx), .data_i(data), .rd_idx(rd_idx), .rd_data_o(rd_data),
    .tap_a_o(tap_a), .tap_b_o(tap_b), .tap_c_o(tap_c), .tap_d_o(tap_d),
    .count_o(count), .full_o(full), .drop_o(drop)
  );

  sha_word_window #(
    .WIDTH(32), .DEPTH(12), .IDX_W(4),
    .TAP_A(0), .TAP_B(1), .TAP_C(5), .TAP_D(10)
  ) u_small (
    .CLK(clk), .RST(rst_n), .clear(s_clear), .shift(s_shift), .load(s_load),
    .load_idx(s_load_idx), .data_i(s_data), .rd_idx(s_rd_idx), .rd_data_o(s_rd_data),
    .tap_a_o(s_tap_a), .tap_b_o(s_tap_b), .tap_c_o(s_tap_c), .tap_d_o(s_tap_d),
    .count_o(s_count), .full_o(s_full), .drop_o(s_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 0; shift = 0; load = 0;
  endtask

  task automatic do_shift(input logic [31:0] v);
    shift = 1; data = v;
    tick();
    idle();
  endtask

  task automatic read_slot(input logic [3:0] idx, output logic [31:0] v);
    rd_idx = idx;
    #0.1;
    v = rd_data;
  endtask

  task automatic read_small(input logic [3:0] idx, output logic [31:0] v);
    s_rd_idx = idx;
    #0.1;
    v = s_rd_data;
  endtask

  logic [31:0] v;
  logic [31:0] small_exp [12];

  initial begin
    rst_n = 0;
    idle(); load_idx = 0; rd_idx = 0; data = 0;
    s_clear = 0; s_shift = 0; s_load = 0; s_load_idx = 0; s_rd_idx = 0; s_data = 0;

    // reset then idle
    #12 rst_n = 1;
    repeat (5) tick();
    check_eq("rst_tap_a", tap_a, 0);
    check_eq("rst_tap_d", tap_d, 0);
    read_slot(15, v); check_eq("rst_rd15", v, 0);
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_full", 32'(full), 0);
    check_eq("rst_drop", 32'(drop), 0);

    // indexed load leaves count untouched
    load = 1; load_idx = 4; data = 32'h0000_1234;
    tick(); idle();
    read_slot(4, v); check_eq("load_slot4", v, 32'h0000_1234);
    check_eq("load_count", 32'(count), 0);

    // fill with 1..16
    for (int k = 1; k <= 15; k++) do_shift(32'(k));
    check_eq("fill15_count", 32'(count), 15);
    check_eq("fill15_full", 32'(full), 0);
    do_shift(16);
    check_eq("fill_count", 32'(count), 16);
    check_eq("fill_full", 32'(full), 1);
    check_eq("fill_drop", 32'(drop), 0);
    check_eq("fill_tap_a", tap_a, 1);
    check_eq("fill_tap_b", tap_b, 2);
    check_eq("fill_tap_c", tap_c, 10);
    check_eq("fill_tap_d", tap_d, 15);
    read_slot(15, v); check_eq("fill_rd15", v, 16);

    // overflow
    do_shift(17);
    check_eq("ovf_drop", 32'(drop), 1);
    check_eq("ovf_tap_a", tap_a, 2);
    read_slot(15, v); check_eq("ovf_rd15", v, 17);
    check_eq("ovf_count", 32'(count), 16);

    // shift with load: shift wins, second drop back-to-back
    shift = 1; load = 1; load_idx = 3; data = 32'hDEAD_BEEF;
    tick(); idle();
    check_eq("prio_drop", 32'(drop), 1);
    for (int i = 0; i < 16; i++) begin
      read_slot(4'(i), v);
      check_eq($sformatf("prio_slot%0d", i), v, (i < 15) ? 32'(i + 3) : 32'hDEAD_BEEF);
    end
    tick();
    check_eq("idle_drop", 32'(drop), 0);
    read_slot(15, v); check_eq("idle_hold15", v, 32'hDEAD_BEEF);

    // clear beats shift
    clear = 1; shift = 1; data = 32'h5555_5555;
    tick(); idle();
    check_eq("clr_count", 32'(count), 0);
    check_eq("clr_full", 32'(full), 0);
    check_eq("clr_drop", 32'(drop), 0);
    check_eq("clr_tap_a", tap_a, 0);
    check_eq("clr_tap_d", tap_d, 0);
    read_slot(15, v); check_eq("clr_rd15", v, 0);

    // asynchronous reset mid-fill
    for (int k = 0; k < 7; k++) do_shift(32'h100 + 32'(k));
    check_eq("pre_arst_count", 32'(count), 7);
    read_slot(15, v); check_eq("pre_arst_rd15", v, 32'h106);
    #1 rst_n = 0;
    #0.5;
    check_eq("arst_count", 32'(count), 0);
    check_eq("arst_tap_d", tap_d, 0);
    read_slot(15, v); check_eq("arst_rd15", v, 0);
    tick();
    #2 rst_n = 1;
    do_shift(32'hCAFE_0001);
    check_eq("post_arst_count", 32'(count), 1);
    read_slot(15, v); check_eq("post_arst_rd15", v, 32'hCAFE_0001);

    // DEPTH 12 instance: load and range
    s_shift = 1;
    s_data = 32'h11; tick();
    s_data = 32'h22; tick();
    s_data = 32'h33; tick();
    s_shift = 0;
    check_eq("s_count3", 32'(s_count), 3);
    check_eq("s_tap_d", s_tap_d, 32'h22);
    s_load = 1; s_load_idx = 5; s_data = 32'hA5A5_A5A5;
    tick();
    s_load_idx = 13; s_data = 32'hFFFF_FFFF;
    tick();
    s_load = 0;
    check_eq("s_count_load", 32'(s_count), 3);
    check_eq("s_tap_c", s_tap_c, 32'hA5A5_A5A5);
    for (int i = 0; i < 12; i++) small_exp[i] = 0;
    small_exp[5] = 32'hA5A5_A5A5;
    small_exp[9] = 32'h11; small_exp[10] = 32'h22; small_exp[11] = 32'h33;
    for (int i = 0; i < 12; i++) begin
      read_small(4'(i), v);
      check_eq($sformatf("s_slot%0d", i), v, small_exp[i]);
    end
    read_small(12, v); check_eq("s_rd12", v, 0);
    read_small(14, v); check_eq("s_rd14", v, 0);
    check_eq("s_full", 32'(s_full), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
